// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the i-cache / d-cache refill port arbiter.
// State codes are one-hot so each busy state is decoded from a single bit.
package cache_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'b001,
        ARB_BUSY_I = 3'b010,
        ARB_BUSY_D = 3'b100
    } arb_state_e;

    localparam logic [7:0] ARB_TIMEOUT_DEFAULT = 8'd255;

    // Command presented to the memory bridge, latched at grant time.
    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } mem_cmd_t;

    localparam mem_cmd_t MEM_CMD_NONE = '{we: 1'b0, addr: 64'd0, wdata: 64'd0, wstrb: 8'd0};

    // The i-cache fetches one 32-bit word out of the 64-bit memory beat.
    function automatic logic [31:0] fetch_word(input logic [63:0] beat, input logic upper);
        return upper ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_arb_rr2.sv
// Two-way round-robin pick: on a tie the side not granted last time wins.
module arb_rr2 (
    input  logic i_req,
    input  logic d_req,
    input  logic last_d,
    output logic grant_i,
    output logic grant_d
);

    always_comb begin
        grant_i = i_req && (!d_req || last_d);
        grant_d = d_req && (!i_req || !last_d);
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one cache-refill memory port between the i-cache and d-cache,
// one transaction at a time, with a watchdog that forces an error completion.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ok,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_wstrb,
    output logic [63:0] d_rdata,
    output logic        d_ok,
    output logic        d_err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ok,
    input  logic [63:0] mem_rdata
);

    arb_state_e state_q, state_d;
    logic       mem_req_q, mem_req_d;
    mem_cmd_t   cmd_q, cmd_d;
    logic       last_d_q, last_d_d;
    logic [7:0] cnt_q, cnt_d;

    logic grant_i, grant_d;
    logic busy_i, busy_d, busy;
    logic timed_out, finish;

    arb_rr2 u_rr (
        .i_req   (i_req),
        .d_req   (d_req),
        .last_d  (last_d_q),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign busy_i = (state_q == ARB_BUSY_I);
    assign busy_d = (state_q == ARB_BUSY_D);
    assign busy   = busy_i || busy_d;

    // cnt_q counts completed busy cycles, so the TIMEOUT-th busy cycle is the last one.
    assign timed_out = busy && !mem_ok && (cnt_q == TIMEOUT - 8'd1);
    assign finish    = busy && (mem_ok || timed_out);

    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        cmd_d     = cmd_q;
        last_d_d  = last_d_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant_i) begin
                    state_d   = ARB_BUSY_I;
                    mem_req_d = 1'b1;
                    cmd_d     = MEM_CMD_NONE;
                    cmd_d.addr = i_addr;
                    cnt_d     = 8'd0;
                end else if (grant_d) begin
                    state_d   = ARB_BUSY_D;
                    mem_req_d = 1'b1;
                    cmd_d     = '{we: d_we, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
                    cnt_d     = 8'd0;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (finish) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    last_d_d  = busy_d;
                    cnt_d     = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
                cnt_d     = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB_IDLE;
            mem_req_q <= 1'b0;
            cmd_q     <= MEM_CMD_NONE;
            last_d_q  <= 1'b1;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            cmd_q     <= cmd_d;
            last_d_q  <= last_d_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_wstrb = cmd_q.wstrb;

    // Completion is reported in the same cycle as mem_ok; a timeout returns zero data.
    always_comb begin
        i_ok    = busy_i && finish;
        i_err   = busy_i && timed_out;
        i_rdata = (busy_i && mem_ok) ? fetch_word(mem_rdata, cmd_q.addr[2]) : 32'd0;
        d_ok    = busy_d && finish;
        d_err   = busy_d && timed_out;
        d_rdata = (busy_d && mem_ok) ? mem_rdata : 64'd0;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised transaction-level bench for cache_mem_arbiter, run with a short watchdog.
module tb_cache_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [63:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ok, i_err;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [63:0] d_addr = '0, d_wdata = '0;
    logic [7:0]  d_wstrb = '0;
    logic [63:0] d_rdata;
    logic        d_ok, d_err;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ok = 1'b0;
    logic [63:0] mem_rdata = '0;

    cache_mem_arbiter #(.TIMEOUT(8'(TO))) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ok(i_ok), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ok(d_ok), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ok(mem_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Reference model: outstanding requests and the side granted most recently.
    bit          m_last_d = 1'b1;
    bit          m_i_pend = 1'b0, m_d_pend = 1'b0;
    logic [63:0] m_ia, m_da, m_dwd;
    logic        m_dwe;
    logic [7:0]  m_dws;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic post_i(input logic [63:0] a);
        m_i_pend = 1'b1; m_ia = a;
        i_req = 1'b1; i_addr = a;
    endtask

    task automatic post_d(input logic we, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] ws);
        m_d_pend = 1'b1; m_dwe = we; m_da = a; m_dwd = wd; m_dws = ws;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws;
    endtask

    // Called at a negedge while the arbiter is idle. lat = cycles after the first
    // busy cycle before mem_ok; lat >= TO means the memory never answers in time.
    task automatic serve(input int lat, input logic [63:0] rd, input bit withdraw);
        bit          win_d, got_ok, err;
        logic [63:0] exp_addr, exp_data;
        if (!m_i_pend && !m_d_pend) begin
            mem_ok = 1'b1; mem_rdata = rd;
            #1;
            check_val("idle_i_ok", i_ok, 0);
            check_val("idle_d_ok", d_ok, 0);
            @(posedge clk); @(negedge clk);
            mem_ok = 1'b0;
            #1;
            check_val("idle_mem_req", mem_req, 0);
            $display("txn %0d: idle cycle, stray mem_ok", n_txn++);
            return;
        end
        win_d    = m_d_pend && (!m_i_pend || !m_last_d);
        exp_addr = win_d ? m_da : m_ia;
        @(posedge clk); @(negedge clk);
        #1;
        check_val("grant_mem_req", mem_req, 1);
        check_val("grant_mem_addr", mem_addr, exp_addr);
        check_val("grant_mem_we", mem_we, win_d ? m_dwe : 1'b0);
        check_val("grant_mem_wstrb", mem_wstrb, win_d ? m_dws : 8'd0);
        if (win_d) check_val("grant_mem_wdata", mem_wdata, m_dwd);
        if (withdraw) begin
            if (win_d) d_req = 1'b0; else i_req = 1'b0;
        end
        err = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            got_ok = (k == lat + 1);
            if (got_ok) begin mem_ok = 1'b1; mem_rdata = rd; end
            #1;
            if (got_ok || k == TO) begin
                err = !got_ok;
                if (win_d) exp_data = err ? 64'd0 : rd;
                else       exp_data = err ? 64'd0 : (m_ia[2] ? {32'd0, rd[63:32]} : {32'd0, rd[31:0]});
                check_val("done_ok",    win_d ? d_ok : i_ok, 1);
                check_val("done_err",   win_d ? d_err : i_err, err);
                check_val("done_rdata", win_d ? d_rdata : {32'd0, i_rdata}, exp_data);
                check_val("other_ok",   win_d ? i_ok : d_ok, 0);
                break;
            end
            check_val("busy_ok", win_d ? d_ok : i_ok, 0);
            check_val("busy_mem_req", mem_req, 1);
            check_val("busy_mem_addr", mem_addr, exp_addr);
            @(posedge clk); @(negedge clk);
        end
        @(posedge clk); @(negedge clk);
        mem_ok = 1'b0;
        if (win_d) begin d_req = 1'b0; m_d_pend = 1'b0; end
        else       begin i_req = 1'b0; m_i_pend = 1'b0; end
        m_last_d = win_d;
        #1;
        check_val("after_mem_req", mem_req, 0);
        check_val("after_ok", i_ok | d_ok, 0);
        $display("txn %0d: owner=%s addr=%h lat=%0d err=%0b withdraw=%0b",
                 n_txn++, win_d ? "D" : "I", exp_addr, lat, err, withdraw);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mem_req"}, mem_req, 0);
        check_val({tag, "_mem_fields"}, {mem_we, mem_wstrb}, 0);
        check_val({tag, "_mem_addr"}, mem_addr, 0);
        check_val({tag, "_mem_wdata"}, mem_wdata, 0);
        check_val({tag, "_oks"}, {i_ok, i_err, d_ok, d_err}, 0);
        check_val({tag, "_rdata"}, d_rdata | {32'd0, i_rdata}, 0);
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Directed: single fetch, d-write, back-to-back ties, timeout, withdraw.
        post_i(64'h8000_0004);
        serve(1, 64'h1111_2222_3333_4444, 1'b0);
        post_d(1'b1, 64'h8000_1000, 64'hDEAD_BEEF_0000_0001, 8'hFF);
        serve(2, 64'h0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            if (!m_i_pend) post_i({$urandom, $urandom});
            if (!m_d_pend) post_d(1'b0, {$urandom, $urandom}, 64'd0, 8'd0);
            serve(1, {$urandom, $urandom}, 1'b0);
        end
        serve(1, {$urandom, $urandom}, 1'b0);
        post_d(1'b1, 64'h8000_2000, 64'h1234, 8'h0F);
        serve(100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        post_i(64'h8000_0000);
        serve(0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        post_i(64'h8000_0010);
        serve(1, 64'h5555_6666_7777_8888, 1'b1);
        serve(0, 64'h0, 1'b0);

        // Randomised traffic including coincident mem_ok/timeout (lat = TO-1).
        for (int r = 0; r < 60; r++) begin
            if (!m_i_pend && $urandom_range(0, 1) == 1) post_i({$urandom, $urandom});
            if (!m_d_pend && $urandom_range(0, 1) == 1)
                post_d(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
            serve($urandom_range(0, TO + 1), {$urandom, $urandom}, $urandom_range(0, 3) == 0);
        end

        // Reset during a d-transaction drops it; the next tie goes to I.
        while (m_i_pend || m_d_pend) serve(1, {$urandom, $urandom}, 1'b0);
        post_d(1'b1, 64'h8000_3000, 64'h77, 8'h01);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1 check_reset_outputs("midreset");
        d_req = 1'b0; m_d_pend = 1'b0; m_last_d = 1'b1;
        @(negedge clk);
        #1 check_val("midreset_no_d_ok", d_ok, 0);
        @(negedge clk);
        rst = 1'b1;
        post_i(64'h8000_4000);
        post_d(1'b0, 64'h8000_5000, 64'd0, 8'd0);
        serve(1, {$urandom, $urandom}, 1'b0);
        serve(1, {$urandom, $urandom}, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
